// File: rtl/ram_stream_reader_pkg.sv
// Shared constants and state encoding for the RAM stream reader.
package ram_stream_reader_pkg;

    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ram_stream_reader_fifo.sv
// Small synchronous FIFO holding read words plus their end-of-burst flag.
module stream_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Burst read sequencer: issues RAM addresses under a FIFO credit limit and
// streams the returned words out with valid/ready and an end-of-burst flag.
//
// state    | meaning
// ST_IDLE  | waiting for a command, cmd_ready high
// ST_ISSUE | issuing one RAM read per cycle while credit allows
// ST_DRAIN | all reads issued, waiting for the last word to be taken
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0] cmd_address,
    input  logic [ADDRESS_WIDTH:0]   cmd_length,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    input  logic [DATA_WIDTH-1:0]    ram_data_out,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy
);
    localparam int LW = ADDRESS_WIDTH + 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_t          state;
    logic [LW-1:0]   issue_left;
    logic [1:0]      pipe_valid;
    logic [1:0]      pipe_last;
    logic            accept;
    logic            credit_ok;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [DATA_WIDTH:0] fifo_head;
    logic [CW:0]     reserved;

    assign accept    = cmd_valid & cmd_ready;
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // Words already in the FIFO plus reads still in the RAM pipe must fit in the FIFO.
    assign reserved  = {1'b0, fifo_count} + (CW+1)'(pipe_valid[0]) + (CW+1)'(pipe_valid[1]);
    assign credit_ok = ~fifo_full && (reserved < (CW+1)'(FIFO_DEPTH));

    assign out_valid = ~fifo_empty;
    assign out_data  = fifo_head[DATA_WIDTH-1:0];
    assign out_last  = fifo_head[DATA_WIDTH] & ~fifo_empty;
    assign fifo_pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            issue_left  <= '0;
            ram_address <= '0;
            pipe_valid  <= '0;
            pipe_last   <= '0;
        end else begin
            pipe_valid <= {pipe_valid[0], 1'b0};
            pipe_last  <= {pipe_last[0], 1'b0};
            case (state)
                ST_IDLE: begin
                    if (accept && cmd_length != '0) begin
                        ram_address   <= cmd_address;
                        issue_left    <= cmd_length - LW'(1);
                        pipe_valid[0] <= 1'b1;
                        pipe_last[0]  <= (cmd_length == LW'(1));
                        state         <= (cmd_length == LW'(1)) ? ST_DRAIN : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (credit_ok) begin
                        ram_address   <= ram_address + 1'b1;
                        issue_left    <= issue_left - LW'(1);
                        pipe_valid[0] <= 1'b1;
                        pipe_last[0]  <= (issue_left == LW'(1));
                        if (issue_left == LW'(1)) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_pop && out_last) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    stream_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pipe_valid[1]),
        .push_data ({pipe_last[1], ram_data_out}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: RAM model mem[a]=a^A5 and a queue of expected burst words.
module tb_ram_stream_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_address = '0;
    logic [8:0] cmd_length = '0;
    logic [7:0] ram_address;
    logic [7:0] ram_data_out = '0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_last;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int words_taken = 0;
    logic [8:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    ram_stream_reader #(.DATA_WIDTH(8), .ADDRESS_WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_address  (cmd_address),
        .cmd_length   (cmd_length),
        .ram_address  (ram_address),
        .ram_data_out (ram_data_out),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_data_out <= ram_address ^ 8'hA5;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Stream monitor: sampled at negedge, values hold through the next posedge.
    always @(negedge clk) begin
        logic [8:0] exp_word;
        if (rst_n) begin
            if (prev_stall) chk_val("stall_hold", {out_valid, out_data}, {1'b1, prev_data});
            chk_val("fifo_le4", 32'(dut.u_fifo.count <= 4), 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk_val("spurious_word", out_valid, 0);
                end else begin
                    exp_word = exp_q.pop_front();
                    chk_val("word", {out_last, out_data}, exp_word);
                    words_taken++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send_cmd(input logic [7:0] a, input logic [8:0] len);
        int n = 0;
        while (!cmd_ready && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        chk_val("cmd_ready_wait", cmd_ready, 1);
        cmd_valid   = 1'b1;
        cmd_address = a;
        cmd_length  = len;
        @(posedge clk);
        for (int i = 0; i < int'(len); i++)
            exp_q.push_back({(i == int'(len) - 1), (a + 8'(i)) ^ 8'hA5});
        #1;
        cmd_valid   = 1'b0;
        cmd_address = 8'($urandom);
        cmd_length  = 9'($urandom);
    endtask

    // mode 0: always ready, 1: random ready, 2: toggle / hold-low / toggle pattern
    task automatic run_until_done(input int mode, input int limit, input string tag);
        int cyc = 0;
        while (cyc < limit && !(exp_q.size() == 0 && !busy)) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom % 4) != 0;
                default: out_ready = (cyc < 6)  ? (cyc % 2 == 0) :
                                     (cyc < 16) ? 1'b0 :
                                     (cyc < 26) ? (cyc % 2 == 0) : 1'b1;
            endcase
            @(posedge clk); #1;
            cyc++;
        end
        chk_val({tag, "_done"}, 32'(exp_q.size() == 0 && !busy), 1);
        chk_val({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    initial begin
        int w0;
        int n;
        logic [7:0] ra;
        logic [8:0] rl;

        #2;
        chk_val("rst_cmd_ready", cmd_ready, 1);
        chk_val("rst_out_valid", out_valid, 0);
        chk_val("rst_out_last", out_last, 0);
        chk_val("rst_busy", busy, 0);
        chk_val("rst_ram_address", ram_address, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic burst with latency and back-to-back output
        out_ready = 1'b1;
        send_cmd(8'h10, 9'd4);
        chk_val("lat_e0_valid", out_valid, 0);
        chk_val("lat_e0_busy", busy, 1);
        chk_val("lat_e0_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1;
        chk_val("lat_e1_valid", out_valid, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            chk_val("burst_valid", out_valid, 1);
            chk_val("burst_last", out_last, 32'(i == 3));
            @(posedge clk); #1;
        end
        chk_val("burst_end_cmd_ready", cmd_ready, 1);
        chk_val("burst_end_busy", busy, 0);
        run_until_done(0, 20, "basic");

        send_cmd(8'hFE, 9'd4);
        run_until_done(0, 50, "wrap");

        send_cmd(8'h37, 9'd8);
        run_until_done(2, 100, "backpressure");

        out_ready = 1'b1;
        send_cmd(8'h33, 9'd0);
        for (int i = 0; i < 8; i++) begin
            chk_val("len0_valid", out_valid, 0);
            chk_val("len0_busy", busy, 0);
            chk_val("len0_cmd_ready", cmd_ready, 1);
            @(posedge clk); #1;
        end

        w0 = words_taken;
        send_cmd(8'h80, 9'd256);
        run_until_done(0, 400, "full_range");
        chk_val("full_range_count", words_taken - w0, 256);

        // Reset while word 3 of 8 is stalled
        w0 = words_taken;
        out_ready = 1'b1;
        send_cmd(8'h40, 9'd8);
        n = 0;
        while (words_taken - w0 < 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk_val("rst_mid_two_words", words_taken - w0, 2);
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk_val("rst_mid_out_valid", out_valid, 0);
        chk_val("rst_mid_out_last", out_last, 0);
        chk_val("rst_mid_busy", busy, 0);
        chk_val("rst_mid_cmd_ready", cmd_ready, 1);
        chk_val("rst_mid_ram_address", ram_address, 0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            chk_val("post_rst_quiet", out_valid, 0);
        end
        send_cmd(8'h22, 9'd5);
        run_until_done(0, 50, "post_rst");

        for (int k = 0; k < 10; k++) begin
            ra = 8'($urandom);
            rl = ($urandom % 5 == 0) ? 9'd0 : 9'($urandom_range(1, 24));
            send_cmd(ra, rl);
            run_until_done(1, 400, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
